// File: rtl/led_cube_pkg.sv
// rtl/led_cube_pkg.sv - shared constants, state enums and voxel indexing for the LED cube scanner
package led_cube_pkg;

  localparam int CUBE_DIM = 8;
  localparam int COORD_W  = 4;

  typedef enum logic {S_BLANK, S_DRIVE} scan_state_t;
  typedef enum logic {C_IDLE, C_RUN} clr_state_t;

  // Column bit for voxel (x, z) inside one Y-plane: 8*z + x
  function automatic logic [5:0] vox_idx(input logic [2:0] x, input logic [2:0] z);
    return {z, x};
  endfunction

endpackage

// File: rtl/led_cube_scanner_if.sv
// rtl/led_cube_scanner_if.sv - voxel write stream and cube driver signals
interface led_cube_scanner_if;
  import led_cube_pkg::*;

  logic               wr_en;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [COORD_W-1:0] wr_z;
  logic               wr_erase;
  logic               clear;
  logic               swap;
  logic               busy;
  logic               swap_done;
  logic               frame_start;
  logic [7:0]         layer_sel;
  logic [63:0]        col_data;

  modport master (
    output wr_en, wr_x, wr_y, wr_z, wr_erase, clear, swap,
    input  busy, swap_done, frame_start, layer_sel, col_data
  );

  modport slave (
    input  wr_en, wr_x, wr_y, wr_z, wr_erase, clear, swap,
    output busy, swap_done, frame_start, layer_sel, col_data
  );

endinterface

// File: rtl/led_voxel_bank.sv
// rtl/led_voxel_bank.sv - one 8x64 voxel frame store
// Single-bit write, whole-plane clear (wins over write) and combinational plane read.
module led_voxel_bank
  import led_cube_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_plane,
  input  logic [5:0]  wr_idx,
  input  logic        wr_val,
  input  logic        clr_en,
  input  logic [2:0]  clr_plane,
  input  logic [2:0]  rd_plane,
  output logic [63:0] rd_data
);

  logic [63:0] planes [CUBE_DIM];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CUBE_DIM; i++) planes[i] <= '0;
    end else if (clr_en) begin
      planes[clr_plane] <= '0;
    end else if (wr_en) begin
      planes[wr_plane][wr_idx] <= wr_val;
    end
  end

  assign rd_data = planes[rd_plane];

endmodule

// File: rtl/led_cube_scanner.sv
// rtl/led_cube_scanner.sv - double-buffered voxel sink and Y-layer multiplexed scan driver
// Writes land in the hidden bank; the shown bank is latched one layer at a time.
module led_cube_scanner
  import led_cube_pkg::*;
#(
  parameter int LAYER_CYCLES = 6250,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                clk,
  input  logic                reset,
  led_cube_scanner_if.slave   bus
);

  localparam int CC_MAX = (LAYER_CYCLES > BLANK_CYCLES) ? LAYER_CYCLES : BLANK_CYCLES;
  localparam int CC_W   = (CC_MAX > 1) ? $clog2(CC_MAX) : 1;
  localparam logic [CC_W-1:0] BLANK_LAST = CC_W'(BLANK_CYCLES - 1);
  localparam logic [CC_W-1:0] LAYER_LAST = CC_W'(LAYER_CYCLES - 1);

  clr_state_t  c_state, c_state_n;
  logic [2:0]  cplane, cplane_n;
  logic        clr_en, busy_q, busy_n;

  scan_state_t s_state, s_state_n;
  logic [2:0]  ly, ly_n;
  logic [CC_W-1:0] cc, cc_n;
  logic        started;
  logic        bank, bank_n;
  logic        swap_pending, swap_pending_n;
  logic [7:0]  layer_sel_q, layer_sel_n;
  logic [63:0] col_q, col_n;
  logic        frame_q, frame_n;
  logic        swap_done_q, swap_done_n;

  logic        coord_ok, wr_ok;
  logic [5:0]  wr_idx;
  logic [63:0] rd0, rd1, disp_data;

  // Clear FSM: one write-bank plane per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_state <= C_IDLE;
      cplane  <= '0;
      busy_q  <= 1'b0;
    end else begin
      c_state <= c_state_n;
      cplane  <= cplane_n;
      busy_q  <= busy_n;
    end
  end

  always_comb begin
    c_state_n = c_state;
    cplane_n  = cplane;
    clr_en    = 1'b0;
    case (c_state)
      C_IDLE: begin
        if (bus.clear) begin
          c_state_n = C_RUN;
          cplane_n  = 3'd0;
        end
      end
      C_RUN: begin
        clr_en   = 1'b1;
        cplane_n = cplane + 3'd1;
        if (cplane == 3'd7) c_state_n = C_IDLE;
      end
      default: c_state_n = C_IDLE;
    endcase
    busy_n = (c_state_n == C_RUN);
  end

  // A clear request in the same cycle as a write pre-empts the write
  assign coord_ok = !bus.wr_x[3] && !bus.wr_y[3] && !bus.wr_z[3];
  assign wr_ok    = bus.wr_en && (c_state == C_IDLE) && !bus.clear && coord_ok;
  assign wr_idx   = vox_idx(bus.wr_x[2:0], bus.wr_z[2:0]);

  led_voxel_bank u_bank0 (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_ok & bank),
    .wr_plane  (bus.wr_y[2:0]),
    .wr_idx    (wr_idx),
    .wr_val    (~bus.wr_erase),
    .clr_en    (clr_en & bank),
    .clr_plane (cplane),
    .rd_plane  (ly),
    .rd_data   (rd0)
  );

  led_voxel_bank u_bank1 (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_ok & ~bank),
    .wr_plane  (bus.wr_y[2:0]),
    .wr_idx    (wr_idx),
    .wr_val    (~bus.wr_erase),
    .clr_en    (clr_en & ~bank),
    .clr_plane (cplane),
    .rd_plane  (ly),
    .rd_data   (rd1)
  );

  assign disp_data = bank ? rd1 : rd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_state      <= S_BLANK;
      ly           <= '0;
      cc           <= '0;
      started      <= 1'b0;
      bank         <= 1'b0;
      swap_pending <= 1'b0;
      layer_sel_q  <= '0;
      col_q        <= '0;
      frame_q      <= 1'b0;
      swap_done_q  <= 1'b0;
    end else begin
      s_state      <= s_state_n;
      ly           <= ly_n;
      cc           <= cc_n;
      started      <= 1'b1;
      bank         <= bank_n;
      swap_pending <= swap_pending_n;
      layer_sel_q  <= layer_sel_n;
      col_q        <= col_n;
      frame_q      <= frame_n;
      swap_done_q  <= swap_done_n;
    end
  end

  // The first edge after reset only raises frame_start, so the registered pulse
  // lines up with the first layer-0 blanking cycle.
  always_comb begin
    s_state_n      = s_state;
    ly_n           = ly;
    cc_n           = cc + CC_W'(1);
    bank_n         = bank;
    swap_pending_n = swap_pending | bus.swap;
    layer_sel_n    = layer_sel_q;
    col_n          = col_q;
    frame_n        = 1'b0;
    swap_done_n    = 1'b0;
    if (!started) begin
      cc_n    = cc;
      frame_n = 1'b1;
    end else begin
      case (s_state)
        S_BLANK: begin
          if (cc == BLANK_LAST) begin
            s_state_n   = S_DRIVE;
            cc_n        = '0;
            layer_sel_n = 8'b1 << ly;
            col_n       = disp_data;
          end
        end
        S_DRIVE: begin
          if (cc == LAYER_LAST) begin
            s_state_n   = S_BLANK;
            cc_n        = '0;
            ly_n        = ly + 3'd1;
            layer_sel_n = '0;
            if (ly == 3'd7) begin
              frame_n = 1'b1;
              if (swap_pending && !busy_q) begin
                bank_n         = ~bank;
                swap_pending_n = 1'b0;
                swap_done_n    = 1'b1;
              end
            end
          end
        end
        default: s_state_n = S_BLANK;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.swap_done   = swap_done_q;
  assign bus.frame_start = frame_q;
  assign bus.layer_sel   = layer_sel_q;
  assign bus.col_data    = col_q;

endmodule

// File: tb/tb_led_cube_scanner.sv
// tb/tb_led_cube_scanner.sv - directed self-checking bench for led_cube_scanner
module tb_led_cube_scanner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  led_cube_scanner_if cube_if();

  led_cube_scanner #(.LAYER_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cube_if)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc = -1;
  int exp_swap = -1;
  bit track = 1'b0;

  localparam logic [63:0] BIT19 = 64'h0000_0000_0008_0000;
  localparam logic [63:0] BIT60 = 64'h1000_0000_0000_0000;
  localparam logic [63:0] BIT63 = 64'h8000_0000_0000_0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // 2 blank + 4 drive cycles per layer, 48 per frame
  function automatic logic [63:0] exp_layer(input int c);
    int p, l;
    p = c % 6;
    l = (c / 6) % 8;
    return (p >= 2) ? 64'(8'b1 << l) : 64'd0;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (track) begin
      check("layer_sel", 64'(cube_if.layer_sel), exp_layer(cyc));
      check("frame_start", 64'(cube_if.frame_start), (cyc % 48 == 0) ? 64'd1 : 64'd0);
      check("swap_done", 64'(cube_if.swap_done), (cyc == exp_swap) ? 64'd1 : 64'd0);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  task automatic wr(input logic [3:0] x, input logic [3:0] y, input logic [3:0] z, input logic e);
    cube_if.wr_en    = 1'b1;
    cube_if.wr_x     = x;
    cube_if.wr_y     = y;
    cube_if.wr_z     = z;
    cube_if.wr_erase = e;
    tick();
    cube_if.wr_en    = 1'b0;
  endtask

  task automatic pulse_swap();
    cube_if.swap = 1'b1;
    tick();
    cube_if.swap = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_layer_sel"}, 64'(cube_if.layer_sel), 64'd0);
    check({tag, "_col_data"}, cube_if.col_data, 64'd0);
    check({tag, "_busy"}, 64'(cube_if.busy), 64'd0);
    check({tag, "_swap_done"}, 64'(cube_if.swap_done), 64'd0);
    check({tag, "_frame_start"}, 64'(cube_if.frame_start), 64'd0);
  endtask

  initial begin
    cube_if.wr_en    = 1'b0;
    cube_if.wr_x     = '0;
    cube_if.wr_y     = '0;
    cube_if.wr_z     = '0;
    cube_if.wr_erase = 1'b0;
    cube_if.clear    = 1'b0;
    cube_if.swap     = 1'b0;

    // Reset values, then release and let the scan timing be tracked every cycle
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    cyc = -1;
    track = 1'b1;

    // Lit voxel (3,5,2) shows on layer 5 as bit 19 after the swap at cycle 48
    goto(10);
    wr(4'd3, 4'd5, 4'd2, 1'b0);
    pulse_swap();
    exp_swap = 48;
    goto(51);
    check("s2_layer0", cube_if.col_data, 64'd0);
    goto(81);
    check("s2_layer5", cube_if.col_data, BIT19);

    // Out-of-range coordinates are dropped
    goto(84);
    wr(4'd8, 4'd0, 4'd0, 1'b0);
    wr(4'd0, 4'd0, 4'd15, 1'b0);
    pulse_swap();
    exp_swap = 96;
    goto(99);
    check("s3_layer0", cube_if.col_data, 64'd0);
    goto(129);
    check("s3_layer5", cube_if.col_data, 64'd0);

    // Clear beats a same-cycle write; writes during busy are dropped
    goto(130);
    cube_if.clear = 1'b1;
    wr(4'd1, 4'd1, 4'd1, 1'b0);
    cube_if.clear = 1'b0;
    check("s4_busy_start", 64'(cube_if.busy), 64'd1);
    wr(4'd2, 4'd2, 4'd2, 1'b0);
    for (int c = 132; c <= 139; c++) begin
      check("s4_busy", 64'(cube_if.busy), (cyc <= 138) ? 64'd1 : 64'd0);
      if (c < 139) tick();
    end
    wr(4'd4, 4'd6, 4'd7, 1'b0);
    wr(4'd0, 4'd3, 4'd0, 1'b0);
    wr(4'd0, 4'd3, 4'd0, 1'b1);
    pulse_swap();
    exp_swap = 144;
    goto(153);
    check("s4_layer1", cube_if.col_data, 64'd0);
    goto(159);
    check("s4_layer2", cube_if.col_data, 64'd0);
    goto(165);
    check("s4_layer3_erased", cube_if.col_data, 64'd0);
    goto(177);
    check("s4_layer5_cleared", cube_if.col_data, 64'd0);
    goto(183);
    check("s4_layer6", cube_if.col_data, BIT60);

    // Swap requested while busy spans the boundary at 192; double pulse gives one toggle at 240
    goto(188);
    cube_if.clear = 1'b1;
    tick();
    cube_if.clear = 1'b0;
    pulse_swap();
    tick();
    pulse_swap();
    check("s5_busy_at_boundary", 64'(cube_if.busy), 64'd1);
    goto(197);
    check("s5_busy_done", 64'(cube_if.busy), 64'd0);
    wr(4'd7, 4'd7, 4'd7, 1'b0);
    exp_swap = 240;
    goto(231);
    check("s5_layer6_no_swap", cube_if.col_data, BIT60);
    goto(279);
    check("s5_layer6_swapped", cube_if.col_data, 64'd0);
    goto(285);
    check("s5_layer7_swapped", cube_if.col_data, BIT63);

    // Asynchronous reset during layer-4 drive with a clear in progress
    goto(313);
    cube_if.clear = 1'b1;
    tick();
    cube_if.clear = 1'b0;
    tick();
    check("s6_busy_before", 64'(cube_if.busy), 64'd1);
    track = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("s6_async");
    tick();
    tick();
    reset = 1'b0;
    cyc = -1;
    exp_swap = -1;
    track = 1'b1;
    goto(39);
    check("s6_bank0_layer6", cube_if.col_data, 64'd0);
    goto(40);
    pulse_swap();
    exp_swap = 48;
    goto(45);
    check("s6_bank0_layer7", cube_if.col_data, 64'd0);
    goto(87);
    check("s6_bank1_layer6", cube_if.col_data, 64'd0);
    goto(93);
    check("s6_bank1_layer7", cube_if.col_data, 64'd0);
    goto(96);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/led_cube_scanner.md
# led_cube_scanner

Voxel sink and scan driver for the 8x8x8 LED cube: accepts single-voxel write commands from the animation blocks, the consumer of their `enable`/X/Y/Z stream. Holds two frame banks (one written, one displayed) and multiplexes the displayed bank onto the cube one Y-layer at a time with inter-layer blanking. Sits between the animation/mode controllers and the cube's layer and column driver pins.

## Interface
- `LAYER_CYCLES`, 6250: clock cycles a layer is driven.
- `BLANK_CYCLES`, 50: cycles all layers are off before each layer is driven; must be ≥1.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `wr_en` in 1: voxel write strobe, one voxel per cycle.
- `wr_x`, `wr_y`, `wr_z` in 4 each: voxel coordinate; only values 0–7 are valid.
- `wr_erase` in 1: 0 sets the voxel lit, 1 clears it.
- `clear` in 1: pulse; zero the entire write bank.
- `swap` in 1: pulse; request a bank exchange at the next frame boundary.
- `busy` out 1: clear in progress; writes are ignored.
- `swap_done` out 1: one-cycle pulse when an exchange takes effect.
- `frame_start` out 1: one-cycle pulse on the first cycle of layer 0 blanking.
- `layer_sel` out 8: one-hot layer enable; bit y drives layer y.
- `col_data` out 64: column pattern for the driven layer; bit `8*z + x`.

## Operation
- Storage: two banks, 8 planes × 64 bits each.
  - `bank` flag selects which is displayed; the other is the write bank.
  - Reset: `bank`=0, so bank 0 is displayed and bank 1 is written.
- Write:
  - On `wr_en`=1 with `busy`=0 and all coordinates <8, write-bank bit [y][8*z+x] ← `~wr_erase` at the clock edge.
  - If any coordinate is ≥8, the write is dropped silently.
  - Writes never touch the displayed bank.
- Clear:
  - FSM states C_IDLE and C_RUN. `clear` in C_IDLE goes to C_RUN with a plane counter at 0.
  - Each cycle zeroes one write-bank plane. After plane 7 it returns to C_IDLE.
  - `busy`=1 for exactly 8 cycles, starting the cycle after `clear`.
  - `clear` while in C_RUN is ignored.
  - `clear` and `wr_en` in the same cycle: clear wins and the write is dropped.
- Scan:
  - FSM states S_BLANK and S_DRIVE; layer counter `ly` 0..7 and cycle counter `cc`.
  - S_BLANK: `layer_sel`=0. After BLANK_CYCLES cycles, go to S_DRIVE.
    - `col_data` ← displayed-bank plane[`ly`] latched on that transition edge.
    - `layer_sel` ← 1<<`ly` on the same edge.
  - S_DRIVE: outputs are held for LAYER_CYCLES cycles. Then go to S_BLANK with `ly`+1, wrapping 7→0.
    - `layer_sel` drops to 0 on that edge; `col_data` holds its value.
- Swap:
  - `swap` sets `swap_pending`; further `swap` pulses while pending have no additional effect.
  - Frame boundary: the edge leaving S_DRIVE with `ly`=7.
  - At a frame boundary with `swap_pending`=1 and `busy`=0: `bank` toggles, `swap_pending` clears, and `swap_done`=1 the following cycle.
  - If `busy`=1 at the boundary, the swap is deferred to the next boundary.
  - After a swap, the new write bank holds the previous display contents. Writers clear it explicitly.

## Timing
- Reset values:
  - Outputs: `layer_sel`=0, `col_data`=0, `busy`=0, `swap_done`=0, `frame_start`=0.
  - State: all bank bits 0, S_BLANK, `ly`=0, `cc`=0, C_IDLE, `swap_pending`=0.
- Reset mid-operation: all of the above is restored immediately (asynchronous). Any clear in progress is abandoned.
- `frame_start` is 1 in the first S_BLANK cycle after reset release, then every 8·(BLANK_CYCLES+LAYER_CYCLES) cycles.
- Layer period is exactly BLANK_CYCLES+LAYER_CYCLES; there are no extra transition cycles.
- Write-to-display latency: the write, then a swap at the next frame boundary, then the affected layer's next S_BLANK→S_DRIVE latch.
- All outputs are registered. Counter widths are sized by `$clog2` of the parameters.

## Structure
- Package `led_cube_pkg`:
  - `CUBE_DIM`=8 and `COORD_W`=4.
  - Function `vox_idx(x,z)` returning `8*z+x`.
  - Scan and clear state enums.
- Sub-module `led_voxel_bank`:
  - One 8×64 store with a single-bit write port, a plane-clear port and a plane read port.
  - Instantiated twice. The top level steers write and clear to the write bank and reads from the display bank.

## Test plan
All scenarios use LAYER_CYCLES=4, BLANK_CYCLES=2.
- Reset release: `frame_start` pulses at cycle 0. `layer_sel` is 0 for 2 cycles, then 8'h01 for 4 cycles, then 0, then 8'h02. Period is 6 cycles per layer and 48 per frame.
- Write (3,5,2) lit, then `swap`: after the next frame boundary `swap_done` pulses. When `layer_sel`=8'h20, `col_data` has only bit 19 set.
- Write (8,0,0) and (0,0,15): no bank bit changes. All-zero `col_data` persists after a swap.
- `clear` and `wr_en` (1,1,1) in the same cycle: `busy` is high for 8 cycles, the write is dropped, and a write issued during `busy` is also dropped.
- `swap` asserted while `busy`=1 across a frame boundary: no `swap_done` at that boundary. `swap_done` pulses at the next boundary; a double `swap` pulse yields one toggle.
- Assert `reset` mid-S_DRIVE of layer 4 with bank bits set: outputs go to 0 at once and all banks read 0 after reset release.
